// File: rtl/main_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_arbiter
// Brief    : Round-robin arbiter placing two cache requesters in front of the
//            single-ported main memory, one transaction in flight at a time.
// Revision : 1.0
// ============================================================================
module main_memory_arbiter #(
    parameter int ADDR_LEN  = 16,
    parameter int MEMORY_DW = 256,
    parameter int MEMORY_MW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_cmd_valid,
    output logic                 req0_cmd_ready,
    input  logic                 req0_cmd_read,
    input  logic [ADDR_LEN-1:0]  req0_cmd_addr,
    input  logic [MEMORY_DW-1:0] req0_cmd_wdata,
    input  logic [MEMORY_MW-1:0] req0_cmd_wmask,
    output logic                 req0_rsp_valid,
    input  logic                 req0_rsp_ready,
    output logic [MEMORY_DW-1:0] req0_rsp_rdata,

    input  logic                 req1_cmd_valid,
    output logic                 req1_cmd_ready,
    input  logic                 req1_cmd_read,
    input  logic [ADDR_LEN-1:0]  req1_cmd_addr,
    input  logic [MEMORY_DW-1:0] req1_cmd_wdata,
    input  logic [MEMORY_MW-1:0] req1_cmd_wmask,
    output logic                 req1_rsp_valid,
    input  logic                 req1_rsp_ready,
    output logic [MEMORY_DW-1:0] req1_rsp_rdata,

    output logic                 mem_cs,
    output logic                 mem_cmd_valid,
    input  logic                 mem_cmd_ready,
    output logic                 mem_cmd_read,
    output logic [ADDR_LEN-1:0]  mem_cmd_addr,
    output logic [MEMORY_DW-1:0] mem_cmd_wdata,
    output logic [MEMORY_MW-1:0] mem_cmd_wmask,
    input  logic                 mem_rsp_valid,
    output logic                 mem_rsp_ready,
    input  logic [MEMORY_DW-1:0] mem_rsp_rdata,

    output logic                 arb_busy,
    output logic                 arb_owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 rr_last_q, rr_last_d;
    logic                 owner_q, owner_d;
    logic                 read_q, read_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [MEMORY_DW-1:0] wdata_q, wdata_d;
    logic [MEMORY_MW-1:0] wmask_q, wmask_d;

    logic                 w_any_valid;
    logic                 w_winner;
    logic                 w_owner_rsp_ready;

    // On contention the port that did not win last time goes first.
    always_comb begin
        w_any_valid = req0_cmd_valid | req1_cmd_valid;
        if (req0_cmd_valid && req1_cmd_valid) begin
            w_winner = ~rr_last_q;
        end else begin
            w_winner = req1_cmd_valid;
        end
        w_owner_rsp_ready = owner_q ? req1_rsp_ready : req0_rsp_ready;
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        read_d    = read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        case (state_q)
            ST_IDLE: begin
                // The winner always sees ready, so any valid is a handshake.
                if (w_any_valid) begin
                    state_d   = ST_CMD;
                    owner_d   = w_winner;
                    rr_last_d = w_winner;
                    read_d    = w_winner ? req1_cmd_read  : req0_cmd_read;
                    addr_d    = w_winner ? req1_cmd_addr  : req0_cmd_addr;
                    wdata_d   = w_winner ? req1_cmd_wdata : req0_cmd_wdata;
                    wmask_d   = w_winner ? req1_cmd_wmask : req0_cmd_wmask;
                end
            end
            ST_CMD: begin
                if (mem_cmd_ready) begin
                    state_d = read_q ? ST_RSP : ST_IDLE;
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid && w_owner_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
            owner_q   <= 1'b0;
            read_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
        end
    end

    // Outputs are forced low while reset is held so nothing handshakes.
    always_comb begin
        req0_cmd_ready = 1'b0;
        req1_cmd_ready = 1'b0;
        req0_rsp_valid = 1'b0;
        req1_rsp_valid = 1'b0;
        req0_rsp_rdata = '0;
        req1_rsp_rdata = '0;
        mem_cs         = 1'b0;
        mem_cmd_valid  = 1'b0;
        mem_cmd_read   = 1'b0;
        mem_cmd_addr   = '0;
        mem_cmd_wdata  = '0;
        mem_cmd_wmask  = '0;
        mem_rsp_ready  = 1'b0;
        arb_busy       = 1'b0;
        arb_owner      = 1'b0;
        if (rst_n) begin
            arb_busy  = (state_q != ST_IDLE);
            arb_owner = owner_q;
            case (state_q)
                ST_IDLE: begin
                    req0_cmd_ready = w_any_valid & ~w_winner;
                    req1_cmd_ready = w_any_valid &  w_winner;
                end
                ST_CMD: begin
                    mem_cs        = 1'b1;
                    mem_cmd_valid = 1'b1;
                    mem_cmd_read  = read_q;
                    mem_cmd_addr  = addr_q;
                    mem_cmd_wdata = wdata_q;
                    mem_cmd_wmask = wmask_q;
                end
                ST_RSP: begin
                    mem_rsp_ready = w_owner_rsp_ready;
                    if (owner_q) begin
                        req1_rsp_valid = mem_rsp_valid;
                        req1_rsp_rdata = mem_rsp_rdata;
                    end else begin
                        req0_rsp_valid = mem_rsp_valid;
                        req0_rsp_rdata = mem_rsp_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_memory_arbiter
// Brief    : Directed and random stimulus against a transaction-level model of
//            the arbiter plus a behavioural main memory.
// Revision : 1.0
// ============================================================================
module tb_main_memory_arbiter;
    localparam int AW    = 16;
    localparam int DW    = 256;
    localparam int MW    = 32;
    localparam int DELAY = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic          req0_cmd_valid, req0_cmd_ready, req0_cmd_read;
    logic [AW-1:0] req0_cmd_addr;
    logic [DW-1:0] req0_cmd_wdata;
    logic [MW-1:0] req0_cmd_wmask;
    logic          req0_rsp_valid, req0_rsp_ready;
    logic [DW-1:0] req0_rsp_rdata;
    logic          req1_cmd_valid, req1_cmd_ready, req1_cmd_read;
    logic [AW-1:0] req1_cmd_addr;
    logic [DW-1:0] req1_cmd_wdata;
    logic [MW-1:0] req1_cmd_wmask;
    logic          req1_rsp_valid, req1_rsp_ready;
    logic [DW-1:0] req1_rsp_rdata;
    logic          mem_cs, mem_cmd_valid, mem_cmd_ready, mem_cmd_read;
    logic [AW-1:0] mem_cmd_addr;
    logic [DW-1:0] mem_cmd_wdata;
    logic [MW-1:0] mem_cmd_wmask;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_rdata;
    logic          arb_busy, arb_owner;

    always #5 clk = ~clk;

    main_memory_arbiter #(.ADDR_LEN(AW), .MEMORY_DW(DW), .MEMORY_MW(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_cmd_valid(req0_cmd_valid), .req0_cmd_ready(req0_cmd_ready),
        .req0_cmd_read(req0_cmd_read), .req0_cmd_addr(req0_cmd_addr),
        .req0_cmd_wdata(req0_cmd_wdata), .req0_cmd_wmask(req0_cmd_wmask),
        .req0_rsp_valid(req0_rsp_valid), .req0_rsp_ready(req0_rsp_ready),
        .req0_rsp_rdata(req0_rsp_rdata),
        .req1_cmd_valid(req1_cmd_valid), .req1_cmd_ready(req1_cmd_ready),
        .req1_cmd_read(req1_cmd_read), .req1_cmd_addr(req1_cmd_addr),
        .req1_cmd_wdata(req1_cmd_wdata), .req1_cmd_wmask(req1_cmd_wmask),
        .req1_rsp_valid(req1_rsp_valid), .req1_rsp_ready(req1_rsp_ready),
        .req1_rsp_rdata(req1_rsp_rdata),
        .mem_cs(mem_cs), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_read(mem_cmd_read), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wmask(mem_cmd_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] wd,
                                                 input logic [MW-1:0] wm);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Behavioural memory contents and the golden image seen by requesters
    logic [DW-1:0] mem_arr [0:2047];
    logic [DW-1:0] golden  [0:2047];

    // Transaction-level model: at most one transaction, either issuing or awaiting data
    bit            m_txn = 0, m_rsp = 0, m_owner = 0, m_last = 1, m_read = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [MW-1:0] m_wmask = '0;

    // Expected outputs and negedge snapshots
    logic          e_r0, e_r1, e_cs, e_cv, e_crd, e_mrr, e_v0, e_v1, e_busy, e_own;
    logic [AW-1:0] e_ca;
    logic [DW-1:0] e_cwd, e_d0, e_d1;
    logic [MW-1:0] e_cwm;
    logic          s_rst = 0, s_v0 = 0, s_v1 = 0, s_r0 = 0, s_r1 = 0, s_rd0 = 0, s_rd1 = 0;
    logic          s_mcr = 0, s_mrv = 0, s_rr0 = 0, s_rr1 = 0;
    logic [AW-1:0] s_a0 = '0, s_a1 = '0;
    logic [DW-1:0] s_wd0 = '0, s_wd1 = '0, s_d0 = '0, s_d1 = '0;
    logic [MW-1:0] s_wm0 = '0, s_wm1 = '0;
    logic          d_mcv = 0, d_read = 0, d_mrr = 0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [MW-1:0] d_wmask = '0;
    int            grants[$];

    // Memory model state
    bit            mv = 0, stall = 0, rnd_mready = 0;
    int            cnt = 0;
    logic [DW-1:0] md = '0;

    always @(negedge clk) begin
        e_r0 = 0; e_r1 = 0; e_cs = 0; e_cv = 0; e_crd = 0; e_mrr = 0;
        e_v0 = 0; e_v1 = 0; e_busy = 0; e_own = 0;
        e_ca = '0; e_cwd = '0; e_cwm = '0; e_d0 = '0; e_d1 = '0;
        if (rst_n) begin
            e_busy = m_txn;
            e_own  = m_owner;
            if (!m_txn) begin
                e_r0 = req0_cmd_valid && (!req1_cmd_valid || m_last);
                e_r1 = req1_cmd_valid && (!req0_cmd_valid || !m_last);
            end else if (!m_rsp) begin
                e_cs = 1; e_cv = 1; e_crd = m_read;
                e_ca = m_addr; e_cwd = m_wdata; e_cwm = m_wmask;
            end else begin
                e_mrr = m_owner ? req1_rsp_ready : req0_rsp_ready;
                if (m_owner) begin e_v1 = mem_rsp_valid; e_d1 = mem_rsp_rdata; end
                else begin e_v0 = mem_rsp_valid; e_d0 = mem_rsp_rdata; end
            end
        end
        chk("req0_cmd_ready", DW'(req0_cmd_ready), DW'(e_r0));
        chk("req1_cmd_ready", DW'(req1_cmd_ready), DW'(e_r1));
        chk("mem_cs", DW'(mem_cs), DW'(e_cs));
        chk("mem_cmd_valid", DW'(mem_cmd_valid), DW'(e_cv));
        chk("mem_cmd_read", DW'(mem_cmd_read), DW'(e_crd));
        chk("mem_cmd_addr", DW'(mem_cmd_addr), DW'(e_ca));
        chk("mem_cmd_wdata", mem_cmd_wdata, e_cwd);
        chk("mem_cmd_wmask", DW'(mem_cmd_wmask), DW'(e_cwm));
        chk("mem_rsp_ready", DW'(mem_rsp_ready), DW'(e_mrr));
        chk("req0_rsp_valid", DW'(req0_rsp_valid), DW'(e_v0));
        chk("req1_rsp_valid", DW'(req1_rsp_valid), DW'(e_v1));
        chk("req0_rsp_rdata", req0_rsp_rdata, e_d0);
        chk("req1_rsp_rdata", req1_rsp_rdata, e_d1);
        chk("arb_busy", DW'(arb_busy), DW'(e_busy));
        chk("arb_owner", DW'(arb_owner), DW'(e_own));
        if (rst_n && req0_cmd_valid && req0_cmd_ready) grants.push_back(0);
        if (rst_n && req1_cmd_valid && req1_cmd_ready) grants.push_back(1);
        s_rst = rst_n; s_v0 = req0_cmd_valid; s_v1 = req1_cmd_valid; s_r0 = e_r0; s_r1 = e_r1;
        s_rd0 = req0_cmd_read; s_a0 = req0_cmd_addr; s_wd0 = req0_cmd_wdata; s_wm0 = req0_cmd_wmask;
        s_rd1 = req1_cmd_read; s_a1 = req1_cmd_addr; s_wd1 = req1_cmd_wdata; s_wm1 = req1_cmd_wmask;
        s_mcr = mem_cmd_ready; s_mrv = mem_rsp_valid; s_rr0 = req0_rsp_ready; s_rr1 = req1_rsp_ready;
        s_d0 = req0_rsp_rdata; s_d1 = req1_rsp_rdata;
        d_mcv = mem_cmd_valid; d_read = mem_cmd_read; d_addr = mem_cmd_addr;
        d_wdata = mem_cmd_wdata; d_wmask = mem_cmd_wmask; d_mrr = mem_rsp_ready;
    end

    always @(posedge clk) begin
        if (!s_rst) begin
            m_txn = 0; m_rsp = 0; m_owner = 0; m_last = 1; m_read = 0;
            m_addr = '0; m_wdata = '0; m_wmask = '0;
        end else if (!m_txn) begin
            if ((s_v0 && s_r0) || (s_v1 && s_r1)) begin
                m_owner = !(s_v0 && s_r0);
                m_read  = m_owner ? s_rd1 : s_rd0;
                m_addr  = m_owner ? s_a1  : s_a0;
                m_wdata = m_owner ? s_wd1 : s_wd0;
                m_wmask = m_owner ? s_wm1 : s_wm0;
                m_txn = 1; m_rsp = 0; m_last = m_owner;
                if (!m_read) golden[m_addr[15:5]] = apply_mask(golden[m_addr[15:5]], m_wdata, m_wmask);
            end
        end else if (!m_rsp) begin
            if (s_mcr) begin
                if (m_read) m_rsp = 1;
                else m_txn = 0;
            end
        end else if (s_mrv && (m_owner ? s_rr1 : s_rr0)) begin
            chk("e2e_read_data", m_owner ? s_d1 : s_d0, golden[m_addr[15:5]]);
            m_txn = 0; m_rsp = 0;
        end
        // Memory: countdown before accept so an accepted read waits DELAY edges
        if (!s_rst) begin
            mv = 0; cnt = 0;
        end else begin
            if (mv && d_mrr) mv = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) mv = 1;
            end
            if (d_mcv && s_mcr) begin
                if (d_read) begin cnt = DELAY; md = mem_arr[d_addr[15:5]]; end
                else mem_arr[d_addr[15:5]] = apply_mask(mem_arr[d_addr[15:5]], d_wdata, d_wmask);
            end
        end
        #1;
        mem_rsp_valid = mv;
        mem_rsp_rdata = mv ? md : rand256();
        mem_cmd_ready = stall ? 1'b0 : (rnd_mready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input bit v, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        if (!p) begin
            req0_cmd_valid = v; req0_cmd_read = rd; req0_cmd_addr = a;
            req0_cmd_wdata = wd; req0_cmd_wmask = wm;
        end else begin
            req1_cmd_valid = v; req1_cmd_read = rd; req1_cmd_addr = a;
            req1_cmd_wdata = wd; req1_cmd_wmask = wm;
        end
    endtask

    // Returns just after the accepting edge
    task automatic issue(input bit p, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        int n;
        logic ok;
        n = 0;
        drive(p, 1, rd, a, wd, wm);
        do begin
            @(negedge clk);
            n++;
            ok = p ? req1_cmd_ready : req0_cmd_ready;
        end while (!ok && n < 100);
        chk("cmd_accept", DW'(ok), DW'(1'b1));
        tick();
        drive(p, 0, 0, '0, '0, '0);
    endtask

    task automatic wait_rsp(input bit p, output logic [DW-1:0] data);
        int n;
        logic ok;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            ok = p ? (req1_rsp_valid && req1_rsp_ready) : (req0_rsp_valid && req0_rsp_ready);
        end while (!ok && n < 100);
        chk("rsp_handshake", DW'(ok), DW'(1'b1));
        data = p ? req1_rsp_rdata : req0_rsp_rdata;
        tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (arb_busy && n < 200);
        chk("return_idle", DW'(arb_busy), DW'(1'b0));
        tick();
    endtask

    task automatic wait_valid0();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req0_rsp_valid && n < 100);
        chk("rsp_valid_seen", DW'(req0_rsp_valid), DW'(1'b1));
    endtask

    task automatic wait_grants(input int k);
        int n;
        n = 0;
        while (grants.size() < k && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("grant_count", DW'(grants.size() >= k), DW'(1'b1));
        #1;
    endtask

    logic [DW-1:0] rd;
    bit acc0, acc1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        req0_rsp_ready = 1; req1_rsp_ready = 1;
        mem_cmd_ready = 1; mem_rsp_valid = 0; mem_rsp_rdata = '0;
        for (int i = 0; i < 2048; i++) begin
            mem_arr[i] = rand256();
            golden[i] = mem_arr[i];
        end
        mem_arr[2] = {32{8'hA5}}; golden[2] = mem_arr[2];
        mem_arr[8] = {32{8'hEE}}; golden[8] = mem_arr[8];

        // Reset state
        repeat (3) tick();
        rst_n = 1;
        @(negedge clk);
        chk("reset_busy", DW'(arb_busy), DW'(1'b0));
        chk("reset_owner", DW'(arb_owner), DW'(1'b0));
        chk("reset_mem_cmd_valid", DW'(mem_cmd_valid), DW'(1'b0));
        chk("reset_rdata0", req0_rsp_rdata, '0);
        tick();

        // Single read from port 0, command one cycle after acceptance
        issue(0, 1, 16'h0040, '0, '0);
        @(negedge clk);
        chk("read0_mem_cmd_valid", DW'(mem_cmd_valid), DW'(1'b1));
        chk("read0_mem_cmd_addr", DW'(mem_cmd_addr), DW'(16'h0040));
        wait_rsp(0, rd);
        chk("read0_rdata", rd, {32{8'hA5}});

        // Alternating grants under constant contention
        rst_n = 0; tick(); rst_n = 1;
        grants.delete();
        drive(0, 1, 1, 16'h0040, '0, '0);
        drive(1, 1, 1, 16'h0100, '0, '0);
        wait_grants(4);
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        if (grants.size() >= 4) begin
            chk("grant_0", DW'(grants[0]), DW'(0));
            chk("grant_1", DW'(grants[1]), DW'(1));
            chk("grant_2", DW'(grants[2]), DW'(0));
            chk("grant_3", DW'(grants[3]), DW'(1));
        end
        wait_idle();

        // Partial write then read back the merged line
        issue(1, 0, 16'h0100, {32{8'h11}}, 32'h0000FFFF);
        wait_idle();
        issue(0, 1, 16'h0100, '0, '0);
        wait_rsp(0, rd);
        chk("merged_line", rd, {{16{8'hEE}}, {16{8'h11}}});

        // Response backpressure holds the response
        req0_rsp_ready = 0;
        issue(0, 1, 16'h0040, '0, '0);
        wait_valid0();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", DW'(req0_rsp_valid), DW'(1'b1));
            chk("bp_rdata", req0_rsp_rdata, {32{8'hA5}});
            chk("bp_mem_rsp_ready", DW'(mem_rsp_ready), DW'(1'b0));
        end
        tick();
        req0_rsp_ready = 1;
        wait_rsp(0, rd);
        chk("bp_final_rdata", rd, {32{8'hA5}});

        // Memory command stall keeps the command stable
        stall = 1;
        issue(1, 0, 16'h0200, {32{8'h5A}}, 32'hF0F0F0F0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", DW'(mem_cmd_valid), DW'(1'b1));
            chk("stall_addr", DW'(mem_cmd_addr), DW'(16'h0200));
            chk("stall_wmask", DW'(mem_cmd_wmask), DW'(32'hF0F0F0F0));
        end
        stall = 0;
        wait_idle();

        // Reset while waiting on a response
        req0_rsp_ready = 0;
        issue(0, 1, 16'h0040, '0, '0);
        wait_valid0();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        req0_rsp_ready = 1;
        @(negedge clk);
        chk("post_reset_busy", DW'(arb_busy), DW'(1'b0));
        chk("post_reset_rsp_valid", DW'(req0_rsp_valid), DW'(1'b0));
        tick();
        grants.delete();
        drive(0, 1, 1, 16'h0040, '0, '0);
        drive(1, 1, 1, 16'h0100, '0, '0);
        wait_grants(1);
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        if (grants.size() >= 1) chk("post_reset_first_grant", DW'(grants[0]), DW'(0));
        wait_idle();

        // Random traffic
        rnd_mready = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            acc0 = req0_cmd_valid && req0_cmd_ready;
            acc1 = req1_cmd_valid && req1_cmd_ready;
            tick();
            if (acc0) req0_cmd_valid = 0;
            if (acc1) req1_cmd_valid = 0;
            if (!req0_cmd_valid && $urandom_range(0, 3) == 0)
                drive(0, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 511)), rand256(), $urandom);
            else if (req0_cmd_valid && $urandom_range(0, 15) == 0)
                req0_cmd_valid = 0;
            if (!req1_cmd_valid && $urandom_range(0, 3) == 0)
                drive(1, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 511)), rand256(), $urandom);
            else if (req1_cmd_valid && $urandom_range(0, 15) == 0)
                req1_cmd_valid = 0;
            req0_rsp_ready = ($urandom_range(0, 3) != 0);
            req1_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        req0_rsp_ready = 1; req1_rsp_ready = 1;
        rnd_mready = 0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_memory_arbiter.md
Name: main_memory_arbiter

Overview:
- Two-requester arbiter in front of the single-ported main memory model; port 0 = instruction cache refill, port 1 = data cache refill/writeback.
- Round-robin grant, one outstanding transaction at a time. The grant is locked from command acceptance until completion.
- Command fields are registered once, then presented to the memory's valid/ready command interface. The read response is routed back to the owning requester.

Parameters:
- ADDR_LEN, 16, byte-address width of all command addresses
- MEMORY_DW, 256, data width of write data and read data
- MEMORY_MW, 32, write byte-mask width (MEMORY_DW/8)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req0_cmd_valid / req1_cmd_valid  in  1  requester command valid
- req0_cmd_ready / req1_cmd_ready  out  1  requester command ready
- req0_cmd_read / req1_cmd_read  in  1  1 = read, 0 = write
- req0_cmd_addr / req1_cmd_addr  in  ADDR_LEN  byte address
- req0_cmd_wdata / req1_cmd_wdata  in  MEMORY_DW  write data
- req0_cmd_wmask / req1_cmd_wmask  in  MEMORY_MW  write byte enables
- req0_rsp_valid / req1_rsp_valid  out  1  read response valid
- req0_rsp_ready / req1_rsp_ready  in  1  read response ready
- req0_rsp_rdata / req1_rsp_rdata  out  MEMORY_DW  read data
- mem_cs  out  1  memory chip select
- mem_cmd_valid  out  1  memory command valid
- mem_cmd_ready  in  1  memory command ready
- mem_cmd_read  out  1  memory read/write
- mem_cmd_addr  out  ADDR_LEN  memory address
- mem_cmd_wdata  out  MEMORY_DW  memory write data
- mem_cmd_wmask  out  MEMORY_MW  memory write mask
- mem_rsp_valid  in  1  memory read response valid
- mem_rsp_ready  out  1  memory response ready
- mem_rsp_rdata  in  MEMORY_DW  memory read data
- arb_busy  out  1  state != IDLE
- arb_owner  out  1  current or last owner index

Behaviour:
- Reset: rst_n is synchronous, active-low, sampled on the clk rising edge.
  - State goes to IDLE; rr_last=1, so port 0 has priority first.
  - Holding registers and arb_owner are cleared to 0.
  - Every output is 0 during and after reset until a request arrives; rdata outputs are 0.
  - Reset mid-transaction abandons it silently; the memory's own reset clears its in-flight state.
- States: IDLE, CMD, RSP.
- IDLE:
  - Winner is combinational. If only one valid, that port wins. If both valid, the port != rr_last wins.
  - cmd_ready = 1 to the winner only, 0 to the loser; both 0 when neither is valid.
  - On winner handshake: capture read, addr, wdata and wmask into holding registers; set owner = winner, rr_last = winner; go to CMD.
- CMD:
  - mem_cmd_valid = 1 and mem_cs = 1; all mem_cmd_* fields are driven from the holding registers and are stable while stalled.
  - On mem_cmd_valid & mem_cmd_ready: a read goes to RSP; a write goes to IDLE. Writes complete at acceptance; the memory's cmd_ready throttles any next command.
  - Both req cmd_ready = 0.
- RSP:
  - mem_rsp_ready = owner's rsp_ready. Owner rsp_valid = mem_rsp_valid; owner rsp_rdata = mem_rsp_rdata.
  - Non-owner rsp_valid = 0, rdata = 0.
  - On mem_rsp_valid & owner rsp_ready, go to IDLE. A stalled response holds indefinitely with no timeout.
- Outside RSP: mem_rsp_ready = 0 and both rsp_valid = 0.
- Latency: request accepted in cycle T gives mem_cmd_valid in T+1. There is no combinational path from req_cmd to mem_cmd.
- Next acceptance: possible in the cycle after a write's memory handshake, or the cycle after a read response handshake. Max throughput is one transaction per 2 cycles plus memory latency.
- A requester that drops valid before being granted is not remembered.

Test Plan:
- Single read port0: addr=0x0040, memory DELAY=2 with preloaded line 0xA5..A5 -> mem_cmd_valid one cycle after accept; req0_rsp_valid with rdata 0xA5..A5; req1_rsp_valid stays 0.
- Simultaneous reads, both valid every cycle after reset -> grant order 0,1,0,1 over 4 transactions; the loser's cmd_ready=0 while the other owns.
- Port1 write addr=0x0100, wdata pattern 0x11.., wmask=0x0000FFFF, then port0 read 0x0100 -> port0 gets 0x11 in the low 16 bytes and the old data in the high bytes; no rsp_valid for the write.
- Response backpressure: port0 read, req0_rsp_ready=0 for 5 cycles -> rsp_valid and rdata held stable; mem_rsp_ready=0; state stays RSP; completes on ready=1.
- Memory cmd stall: mem_cmd_ready forced 0 for 3 cycles in CMD -> mem_cmd_addr, wdata and wmask unchanged; requester cmd_ready=0.
- Reset mid-RSP: assert rst_n=0 for 1 cycle -> next cycle all outputs 0, state IDLE, arb_busy=0, port0 has priority on the next contention.
